// File: rtl/router_pkg.sv
// Shared flit format, injector state encoding and head-flit packing for the router fabric.
package router_pkg;

  localparam int unsigned FLIT_W     = 30;
  localparam int unsigned ADDR_W     = 20;
  localparam int unsigned LEN_W      = 4;
  localparam int unsigned TYPE_W     = 2;
  localparam int unsigned PAYLOAD_W  = FLIT_W - TYPE_W;
  localparam int unsigned TYPE_LO    = FLIT_W - TYPE_W;
  localparam int unsigned TYPE_HI    = FLIT_W - 1;
  localparam int unsigned HEAD_PAD_W = PAYLOAD_W - LEN_W - ADDR_W;

  typedef enum logic [TYPE_W-1:0] {
    FLIT_SINGLE = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_BODY   = 2'b10,
    FLIT_TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } inj_state_e;

  // Flit on the wire: type field in the top bits, payload below.
  typedef struct packed {
    flit_type_e             ftype;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_t;

  // Head payload: zero pad, length, destination at bit 0.
  function automatic logic [PAYLOAD_W-1:0] pack_head(input logic [ADDR_W-1:0] dst,
                                                     input logic [LEN_W-1:0]  len);
    return {{HEAD_PAD_W{1'b0}}, len, dst};
  endfunction

endpackage

// File: rtl/router_credit_counter.sv
// Saturating credit counter toward a downstream buffer; flags credits returned while full.
module router_credit_counter #(
  parameter  int unsigned CREDITS = 4,
  localparam int unsigned CW      = $clog2(CREDITS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic dec_i,
  input  logic inc_i,
  output logic can_send_o,
  output logic err_o
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // Next count: simultaneous send and return cancel; a return at full saturates and flags.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    unique case ({inc_i, dec_i})
      2'b01: begin
        if (count_q != '0) count_d = count_q - CW'(1);
      end
      2'b10: begin
        if (count_q == FULL) err_d = 1'b1;
        else                 count_d = count_q + CW'(1);
      end
      default: ;
    endcase
  end

  // Counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= FULL;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign can_send_o = (count_q != '0);
  assign err_o      = err_q;

endmodule

// File: rtl/router_flit_injector.sv
// Transmit-side network interface: turns (dst, len) requests plus a payload stream into
// head/body/tail flits for one router input port under credit flow control.
// Optional: define ROUTER_INJ_PARITY_EN to register even parity of each flit on flit_par.
module router_flit_injector
  import router_pkg::*;
#(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_dst,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [PAYLOAD_W-1:0]  data_in,
  output logic                  flit_valid,
  output logic [FLIT_W-1:0]     flit_data,
  output logic                  flit_par,
  input  logic                  credit_in,
  output logic                  busy,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic                  err_credit
);

  inj_state_e          state_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    rem_q;
  logic                flit_valid_q;
  flit_t               flit_q;
  flit_t               flit_d;
  logic [CNT_W-1:0]    pkt_cnt_q;
  logic                can_send;
  logic                head_fire;
  logic                body_fire;
  logic                send;

  // Credit tracking toward the router input buffer.
  router_credit_counter #(.CREDITS(CREDITS)) u_credits (
    .clk        (clk),
    .rst        (rst),
    .dec_i      (send),
    .inc_i      (credit_in),
    .can_send_o (can_send),
    .err_o      (err_credit)
  );

  assign head_fire  = (state_q == ST_HEAD) && can_send;
  assign data_ready = (state_q == ST_BODY) && can_send;
  assign body_fire  = data_ready && data_valid;
  assign send       = head_fire || body_fire;

  // Flit to load this cycle; holds the previous flit when nothing is sent.
  always_comb begin
    flit_d = flit_q;
    if (head_fire) begin
      flit_d.ftype   = (len_q == '0) ? FLIT_SINGLE : FLIT_HEAD;
      flit_d.payload = pack_head(dst_q, len_q);
    end else if (body_fire) begin
      flit_d.ftype   = (rem_q == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
      flit_d.payload = data_in;
    end
  end

  // Packet sequencing FSM with registered flit outputs and sent-packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      dst_q        <= '0;
      len_q        <= '0;
      rem_q        <= '0;
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      flit_valid_q <= send;
      flit_q       <= flit_d;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            dst_q   <= req_dst;
            len_q   <= req_len;
            state_q <= ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (can_send) begin
            if (len_q == '0) begin
              state_q   <= ST_IDLE;
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end else begin
              rem_q   <= len_q;
              state_q <= ST_BODY;
            end
          end
        end
        ST_BODY: begin
          if (body_fire) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q   <= ST_IDLE;
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ROUTER_INJ_PARITY_EN
  logic par_q;

  // Even parity registered alongside the flit it covers.
  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^flit_d;
  end

  assign flit_par = par_q;
`else
  assign flit_par = 1'b0;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign flit_valid = flit_valid_q;
  assign flit_data  = flit_q;
  assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: doc/router_flit_injector.md
Name: router_flit_injector

Overview:
- Transmit-side network interface for the routing fabric: the producing end of the 30-bit packet-header interface that the combinational router consumes.
- Accepts a message request (destination, length) plus a payload stream, builds head/body/tail flits and injects them into one router input port.
- Uses credit-based flow control toward the router's input buffer.

Parameters:
- FLIT_W, 30, flit width; matches the router input-port width.
- ADDR_W, 20, destination address field width in the head flit.
- LEN_W, 4, payload length field width (0..15 body flits).
- CREDITS, 4, router input buffer depth; credit counter reset value.
- CNT_W, 16, packet-sent counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  new packet request
- req_ready  out  1  injector can accept a request
- req_dst  in  ADDR_W  destination address
- req_len  in  LEN_W  number of payload flits
- data_valid  in  1  payload word available
- data_ready  out  1  payload word consumed this cycle
- data_in  in  FLIT_W-2  payload word
- flit_valid  out  1  flit on flit_data this cycle
- flit_data  out  FLIT_W  flit: [29:28] type, [27:0] payload
- flit_par  out  1  even parity of flit_data (see Optional Feature)
- credit_in  in  1  one-cycle pulse returning one buffer credit
- busy  out  1  packet in progress (state != IDLE)
- pkt_cnt  out  CNT_W  packets fully sent, wraps
- err_credit  out  1  sticky: credit returned while counter full

Behaviour:
- Flit types [29:28]: 2'b00 SINGLE (head+tail, len 0), 01 HEAD, 10 BODY, 11 TAIL.
- Head payload: {zero pad, len[LEN_W-1:0], dst[ADDR_W-1:0]}, with dst at bit 0.
- Reset values: state IDLE; credits=CREDITS; flit_valid=0; flit_data=0; flit_par=0; pkt_cnt=0; err_credit=0. A reset asserted mid-packet abandons the packet (no tail is emitted) and restores full credits.
- FSM:
  - IDLE: req_ready=1. On req_valid, latch dst/len and go to HEAD.
  - HEAD: if credits>0, send head. Type is SINGLE if len==0, then go to IDLE and increment pkt_cnt. Otherwise type is HEAD, set remaining=len, go to BODY. If credits==0, stall in HEAD.
  - BODY: data_ready = (credits>0), combinational. On data_valid&data_ready, send {BODY, data_in}, or {TAIL, data_in} when remaining==1. Decrement remaining; on tail, go to IDLE and increment pkt_cnt.
- "Send" means flit_data/flit_valid registers load that cycle and are visible the next cycle. flit_valid is high for exactly one cycle per flit and is 0 otherwise; flit_data holds its last value.
- Latency: request accepted in cycle t → head flit_valid in t+2 (credits available). Back-to-back body flits reach one per cycle.
- Credits:
  - Decrement on send, increment on credit_in; both in the same cycle leaves the count unchanged.
  - Never send at 0 credits.
  - credit_in while count==CREDITS with no send: saturate and set err_credit (cleared only by rst).
- req_ready=0 outside IDLE; a request arriving then is held off, not dropped.
- pkt_cnt wraps from 2^CNT_W-1 to 0.

Optional Feature:
- Macro ROUTER_INJ_PARITY_EN.
- Defined: flit_par is registered with flit_data and equals XOR of all FLIT_W bits.
- Undefined: no parity logic; flit_par is tied to 0.

Decomposition:
- Package router_pkg holds:
  - FLIT_W and the type-field offsets.
  - A flit_type_e enum (SINGLE/HEAD/BODY/TAIL).
  - An inj_state_e enum (IDLE/HEAD/BODY).
  - A function that packs the head payload.
- One sub-module, router_credit_counter: saturating up/down counter with a can_send flag and err_credit; reused later by the router's output side.

Test Plan:
- Single packet: req_dst=20'h0A5C3, req_len=0 in cycle 1 → cycle 3 flit_valid=1, flit_data={2'b00, 4'h0, 20'h0A5C3}; credits 4→3; pkt_cnt=1.
- 3-flit packet, data stream 28'h1, 28'h2, 28'h3 always valid → HEAD(len=3), BODY 1, BODY 2, TAIL 3 on consecutive cycles; busy drops after the tail.
- No credit returns, req_len=6 → exactly 4 flits sent, then data_ready=0 and stall. Pulse credit_in twice → 2 more flits; still mid-packet.
- credit_in in the same cycle as a send at credits=1 → count stays 1 and the next flit goes out immediately. credit_in at credits=4 idle → err_credit=1 and remains set.
- rst asserted after the second body flit of a len=5 packet → next cycle state IDLE, credits=4, flit_valid=0; a new request then completes normally.
- With ROUTER_INJ_PARITY_EN: flit_data=30'h0000_0007 → flit_par=1. Without the macro → flit_par=0 always.
